// File: rtl/llc_trace_frontend_pkg.sv
// Shared types for the LLC trace front end.
//   trace_op_e  : decoded trace operation codes
//   llc_req_t   : decoded request (op + tag/index/offset split of the address)
//   fe_state_e  : front-end sequencing states
//   op_class_e  : coarse grouping of raw op codes used by the FSM
package llc_trace_frontend_pkg;

  localparam int TAG_BITS    = 12;
  localparam int INDEX       = 14;
  localparam int BYTE_OFFSET = 6;

  typedef enum logic [3:0] {
    RD_L1D   = 4'd0,
    WR_L1D   = 4'd1,
    RD_L1I   = 4'd2,
    SNP_RD   = 4'd3,
    SNP_WR   = 4'd4,
    SNP_RWIM = 4'd5,
    SNP_INV  = 4'd6,
    CLEAR    = 4'd8,
    PRINT    = 4'd9
  } trace_op_e;

  typedef struct packed {
    trace_op_e              op;
    logic [TAG_BITS-1:0]    tag;
    logic [INDEX-1:0]       index;
    logic [BYTE_OFFSET-1:0] offset;
  } llc_req_t;

  typedef enum logic [1:0] {RUN, DRAIN, SYNC} fe_state_e;

  typedef enum logic [1:0] {OPC_DATA, OPC_CTRL, OPC_ILLEGAL} op_class_e;

  function automatic op_class_e classify(input logic [3:0] op);
    if (op <= 4'd6)                    return OPC_DATA;
    else if (op == 4'd8 || op == 4'd9) return OPC_CTRL;
    else                               return OPC_ILLEGAL;
  endfunction

endpackage

// File: rtl/llc_trace_frontend_if.sv
// Command and request channels of the LLC trace front end.
//   cmd_* : raw trace command, valid/ready (master drives valid/op/addr)
//   req_* : decoded request towards the cache controller (slave drives valid/fields)
//   master: trace source / controller side;  slave: the front end itself
interface llc_trace_frontend_if;
  import llc_trace_frontend_pkg::*;

  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [3:0]             cmd_op;
  logic [31:0]            cmd_addr;

  logic                   req_valid;
  logic                   req_ready;
  trace_op_e              req_op;
  logic [TAG_BITS-1:0]    req_tag;
  logic [INDEX-1:0]       req_index;
  logic [BYTE_OFFSET-1:0] req_offset;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, req_ready,
    input  cmd_ready, req_valid, req_op, req_tag, req_index, req_offset
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, req_ready,
    output cmd_ready, req_valid, req_op, req_tag, req_index, req_offset
  );

endinterface

// File: rtl/llc_trace_frontend_req_fifo.sv
// llc_req_fifo: in-order synchronous FIFO of decoded requests.
//   push/wdata : write, ignored when full (a same-cycle pop does not make room)
//   pop/rdata  : show-ahead head, pop ignored when empty
//   full/empty : derived from pointers carrying an extra wrap bit
module llc_req_fifo
  import llc_trace_frontend_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  llc_req_t wdata,
  input  logic     pop,
  output llc_req_t rdata,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  llc_req_t    mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/llc_trace_frontend.sv
// llc_trace_frontend: decodes raw trace commands, splits the address into
// tag/index/offset, queues them in order and hands them to the cache controller.
// Control ops (CLEAR/PRINT) are only let through once the controller is idle
// and the queue is empty, and nothing follows them until they have been consumed.
//   clk, rst_n     : clock, async active-low reset
//   bus (slave)    : cmd_* in, req_* out
//   ctrl_idle      : controller has nothing in flight
//   illegal_cnt    : saturating count of dropped illegal ops
//   illegal_pulse  : high in the cycle an illegal op is dropped
//
// state | meaning
// RUN   | normal flow; data ops queued, illegal ops dropped
// DRAIN | control op waiting for empty queue and idle controller
// SYNC  | control op queued; waiting for its pop and a later idle cycle
module llc_trace_frontend
  import llc_trace_frontend_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  llc_trace_frontend_if.slave   bus,
  input  logic                  ctrl_idle,
  output logic [CNT_W-1:0]      illegal_cnt,
  output logic                  illegal_pulse
);

  fe_state_e state;
  fe_state_e state_nxt;
  op_class_e op_cls;
  llc_req_t  wdata;
  llc_req_t  head;
  logic      push;
  logic      pop;
  logic      full;
  logic      empty;
  logic      sync_popped;

  assign op_cls = classify(bus.cmd_op);

  assign wdata.op     = trace_op_e'(bus.cmd_op);
  assign wdata.tag    = bus.cmd_addr[31:20];
  assign wdata.index  = bus.cmd_addr[19:6];
  assign wdata.offset = bus.cmd_addr[5:0];

  assign bus.req_valid  = !empty;
  assign bus.req_op     = head.op;
  assign bus.req_tag    = head.tag;
  assign bus.req_index  = head.index;
  assign bus.req_offset = head.offset;
  assign pop            = bus.req_valid && bus.req_ready;

  llc_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.cmd_ready = 1'b0;
    push          = 1'b0;
    illegal_pulse = 1'b0;
    unique case (state)
      RUN: begin
        unique case (op_cls)
          OPC_DATA: begin
            bus.cmd_ready = !full;
            push          = bus.cmd_valid && !full;
          end
          OPC_ILLEGAL: begin
            bus.cmd_ready = 1'b1;
            illegal_pulse = bus.cmd_valid;
          end
          default: begin
            if (bus.cmd_valid) state_nxt = DRAIN;
          end
        endcase
      end
      DRAIN: begin
        bus.cmd_ready = empty && ctrl_idle && (op_cls == OPC_CTRL);
        if (!bus.cmd_valid) begin
          state_nxt = RUN;
        end else if (bus.cmd_ready) begin
          push      = 1'b1;
          state_nxt = SYNC;
        end
      end
      SYNC: begin
        // sync_popped is registered, so the idle check lands after the pop cycle.
        if (sync_popped && ctrl_idle) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 sync_popped <= 1'b0;
    else if (state_nxt != SYNC) sync_popped <= 1'b0;
    else if (pop)               sync_popped <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  illegal_cnt <= '0;
    else if (illegal_pulse && illegal_cnt != '1) illegal_cnt <= illegal_cnt + 1'b1;
  end

endmodule

// File: tb/tb_llc_trace_frontend.sv
module tb_llc_trace_frontend;
  import llc_trace_frontend_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        ctrl_idle;
  logic        ctrl_idle4;
  logic [15:0] illegal_cnt;
  logic        illegal_pulse;
  logic [3:0]  illegal_cnt4;
  logic        illegal_pulse4;

  int total = 0;
  int bad   = 0;
  int pops  = 0;
  llc_req_t exp_q[$];

  llc_trace_frontend_if bus ();
  llc_trace_frontend_if bus4 ();

  llc_trace_frontend #(.FIFO_DEPTH(8), .CNT_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .ctrl_idle     (ctrl_idle),
    .illegal_cnt   (illegal_cnt),
    .illegal_pulse (illegal_pulse)
  );

  llc_trace_frontend #(.FIFO_DEPTH(8), .CNT_W(4)) dut4 (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus4),
    .ctrl_idle     (ctrl_idle4),
    .illegal_cnt   (illegal_cnt4),
    .illegal_pulse (illegal_pulse4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit enq_op(input logic [3:0] op);
    return (op <= 4'd6) || (op == 4'd8) || (op == 4'd9);
  endfunction

  function automatic llc_req_t mk_req(input logic [3:0] op, input logic [31:0] addr);
    llc_req_t r;
    r.op     = trace_op_e'(op);
    r.tag    = addr[31:20];
    r.index  = addr[19:6];
    r.offset = addr[5:0];
    return r;
  endfunction

  // Scoreboard: expected entries pushed on accepted enqueueing commands, compared on pops.
  always @(negedge clk) begin
    llc_req_t exp_r;
    llc_req_t got_r;
    if (rst_n) begin
      if (bus.cmd_valid && bus.cmd_ready && enq_op(bus.cmd_op))
        exp_q.push_back(mk_req(bus.cmd_op, bus.cmd_addr));
      if (bus.req_valid && bus.req_ready) begin
        pops++;
        total++;
        got_r = '{bus.req_op, bus.req_tag, bus.req_index, bus.req_offset};
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_pop: got unexpected request %h, wanted none", got_r);
        end else begin
          exp_r = exp_q.pop_front();
          if (got_r !== exp_r) begin
            bad++;
            $display("FAIL sb_data: got %h want %h", got_r, exp_r);
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_wait(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.req_valid) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_addr = 0; bus.req_ready = 0;
    bus4.cmd_valid = 0; bus4.cmd_op = 0; bus4.cmd_addr = 0; bus4.req_ready = 0;
    ctrl_idle = 1; ctrl_idle4 = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (bus.req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid: got %b want 0", bus.req_valid); end
    total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready); end
    total++; if (illegal_cnt !== 16'd0) begin bad++; $display("FAIL reset_illegal_cnt: got %0d want 0", illegal_cnt); end
    total++; if (illegal_pulse !== 1'b0) begin bad++; $display("FAIL reset_illegal_pulse: got %b want 0", illegal_pulse); end
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_single();
    bit ok;
    pops = 0;
    bus.req_ready = 1; bus.cmd_valid = 1; bus.cmd_op = 4'd0; bus.cmd_addr = 32'hABCD_1234;
    @(negedge clk);
    total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL single_accept: cmd_ready got %b want 1", bus.cmd_ready); end
    cyc();
    bus.cmd_valid = 0;
    @(negedge clk);
    total++; if (bus.req_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %b want 1", bus.req_valid); end
    total++; if (bus.req_op !== RD_L1D) begin bad++; $display("FAIL single_op: got %0d want 0", bus.req_op); end
    total++; if (bus.req_tag !== 12'hABC) begin bad++; $display("FAIL single_tag: got %h want abc", bus.req_tag); end
    total++; if (bus.req_index !== 14'h3448) begin bad++; $display("FAIL single_index: got %h want 3448", bus.req_index); end
    total++; if (bus.req_offset !== 6'h34) begin bad++; $display("FAIL single_offset: got %h want 34", bus.req_offset); end
    cyc();
    drain_wait(ok);
    total++; if (!ok) begin bad++; $display("FAIL single_drain: req_valid stuck at 1, want 0"); end
    total++; if (pops !== 1) begin bad++; $display("FAIL single_pops: got %0d want 1", pops); end
    cyc();
  endtask

  task automatic test_fill();
    bit ok;
    logic want;
    pops = 0;
    bus.req_ready = 0;
    for (int i = 0; i < 9; i++) begin
      bus.cmd_valid = 1; bus.cmd_op = 4'd1; bus.cmd_addr = $urandom;
      want = (i < 8);
      @(negedge clk);
      total++; if (bus.cmd_ready !== want) begin bad++; $display("FAIL fill_ready[%0d]: got %b want %b", i, bus.cmd_ready, want); end
      cyc();
    end
    bus.cmd_valid = 0;
    @(negedge clk);
    total++; if (bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL fill_full_hold: cmd_ready got %b want 0", bus.cmd_ready); end
    cyc();
    bus.req_ready = 1;
    drain_wait(ok);
    total++; if (!ok) begin bad++; $display("FAIL fill_drain: timeout, req_valid still 1 want 0"); end
    total++; if (pops !== 8) begin bad++; $display("FAIL fill_pops: got %0d want 8", pops); end
    total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL fill_ready_back: got %b want 1", bus.cmd_ready); end
    cyc();
  endtask

  task automatic test_illegal();
    logic [3:0] ops [3];
    ops = '{4'd7, 4'd12, 4'd15};
    bus.req_ready = 1;
    for (int i = 0; i < 3; i++) begin
      bus.cmd_valid = 1; bus.cmd_op = ops[i]; bus.cmd_addr = $urandom;
      @(negedge clk);
      total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL illegal_ready[%0d]: got %b want 1", i, bus.cmd_ready); end
      total++; if (illegal_pulse !== 1'b1) begin bad++; $display("FAIL illegal_pulse[%0d]: got %b want 1", i, illegal_pulse); end
      total++; if (bus.req_valid !== 1'b0) begin bad++; $display("FAIL illegal_req_valid[%0d]: got %b want 0", i, bus.req_valid); end
      cyc();
    end
    bus.cmd_valid = 0;
    @(negedge clk);
    total++; if (illegal_pulse !== 1'b0) begin bad++; $display("FAIL illegal_pulse_idle: got %b want 0", illegal_pulse); end
    total++; if (illegal_cnt !== 16'd3) begin bad++; $display("FAIL illegal_cnt: got %0d want 3", illegal_cnt); end
    total++; if (bus.req_valid !== 1'b0) begin bad++; $display("FAIL illegal_no_req: got %b want 0", bus.req_valid); end
    cyc();
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 20; i++) begin
      bus4.cmd_valid = 1; bus4.cmd_op = 4'(10 + (i % 6)); bus4.cmd_addr = $urandom;
      if (i == 14) begin
        @(negedge clk);
        total++; if (illegal_cnt4 !== 4'd14) begin bad++; $display("FAIL sat_cnt_mid: got %0d want 14", illegal_cnt4); end
      end
      cyc();
    end
    bus4.cmd_valid = 0;
    @(negedge clk);
    total++; if (illegal_cnt4 !== 4'hF) begin bad++; $display("FAIL sat_cnt: got %h want f", illegal_cnt4); end
    cyc();
  endtask

  task automatic test_ctrl_drain();
    bit ok;
    pops = 0;
    bus.req_ready = 0; ctrl_idle = 1;
    for (int i = 0; i < 3; i++) begin
      bus.cmd_valid = 1; bus.cmd_op = 4'd0; bus.cmd_addr = $urandom;
      cyc();
    end
    bus.cmd_op = 4'd8; bus.cmd_addr = 32'hC0DE_0008; ctrl_idle = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL ctrl_wait_full[%0d]: got %b want 0", i, bus.cmd_ready); end
      cyc();
    end
    bus.req_ready = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL ctrl_wait_busy[%0d]: got %b want 0", i, bus.cmd_ready); end
      cyc();
    end
    total++; if (pops !== 3) begin bad++; $display("FAIL ctrl_pre_pops: got %0d want 3", pops); end
    ctrl_idle = 1;
    @(negedge clk);
    total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL ctrl_accept: got %b want 1", bus.cmd_ready); end
    cyc();
    bus.cmd_op = 4'd0; bus.cmd_addr = 32'h0F0F_00C1; bus.req_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL sync_hold[%0d]: got %b want 0", i, bus.cmd_ready); end
      total++; if (bus.req_op !== CLEAR || bus.req_valid !== 1'b1) begin bad++; $display("FAIL sync_head[%0d]: got op %0d valid %b want 8/1", i, bus.req_op, bus.req_valid); end
      cyc();
    end
    bus.req_ready = 1; ctrl_idle = 0;
    @(negedge clk);
    total++; if (bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL sync_pop_cycle: got %b want 0", bus.cmd_ready); end
    cyc();
    bus.req_ready = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++; if (bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL sync_busy[%0d]: got %b want 0", i, bus.cmd_ready); end
      cyc();
    end
    ctrl_idle = 1;
    @(negedge clk);
    total++; if (bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL sync_exit_cycle: got %b want 0", bus.cmd_ready); end
    cyc();
    @(negedge clk);
    total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL sync_released: got %b want 1", bus.cmd_ready); end
    cyc();
    bus.cmd_valid = 0; bus.req_ready = 1;
    drain_wait(ok);
    total++; if (!ok) begin bad++; $display("FAIL ctrl_drain: timeout, req_valid still 1 want 0"); end
    total++; if (pops !== 5) begin bad++; $display("FAIL ctrl_pops: got %0d want 5", pops); end
    cyc();
  endtask

  task automatic test_back_to_back();
    bit ok;
    pops = 0;
    bus.req_ready = 0; ctrl_idle = 1;
    for (int i = 0; i < 3; i++) begin
      bus.cmd_valid = 1; bus.cmd_op = 4'($urandom_range(0, 6)); bus.cmd_addr = $urandom;
      cyc();
    end
    bus.req_ready = 1;
    for (int i = 0; i < 100; i++) begin
      bus.cmd_valid = 1; bus.cmd_op = 4'($urandom_range(0, 6)); bus.cmd_addr = $urandom;
      @(negedge clk);
      total++;
      if (bus.cmd_ready !== 1'b1 || bus.req_valid !== 1'b1) begin
        bad++; $display("FAIL b2b_flow[%0d]: ready %b valid %b want 1/1", i, bus.cmd_ready, bus.req_valid);
      end
      cyc();
    end
    bus.cmd_valid = 0;
    drain_wait(ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_drain: timeout, req_valid still 1 want 0"); end
    total++; if (pops !== 103) begin bad++; $display("FAIL b2b_pops: got %0d want 103", pops); end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL b2b_leftover: got %0d want 0", exp_q.size()); end
    cyc();
  endtask

  task automatic test_reset_mid();
    pops = 0;
    bus.req_ready = 0; ctrl_idle = 0;
    for (int i = 0; i < 5; i++) begin
      bus.cmd_valid = 1; bus.cmd_op = 4'd2; bus.cmd_addr = $urandom;
      cyc();
    end
    bus.cmd_op = 4'd9;
    cyc();
    @(negedge clk);
    total++; if (bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL rmid_pre_ready: got %b want 0", bus.cmd_ready); end
    @(posedge clk);
    #3;
    rst_n = 0; bus.cmd_valid = 0; bus.cmd_op = 4'd0;
    #1;
    total++; if (bus.req_valid !== 1'b0) begin bad++; $display("FAIL rmid_req_valid: got %b want 0", bus.req_valid); end
    total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL rmid_cmd_ready: got %b want 1", bus.cmd_ready); end
    total++; if (illegal_cnt !== 16'd0) begin bad++; $display("FAIL rmid_cnt: got %0d want 0", illegal_cnt); end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1; ctrl_idle = 1;
    cyc();
    bus.cmd_valid = 1; bus.cmd_op = 4'd0; bus.cmd_addr = 32'h1234_5678;
    @(negedge clk);
    total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL rmid_accept: got %b want 1", bus.cmd_ready); end
    cyc();
    bus.cmd_valid = 0;
    @(negedge clk);
    total++;
    if (bus.req_valid !== 1'b1 || bus.req_op !== RD_L1D || bus.req_tag !== 12'h123 ||
        bus.req_index !== 14'h1159 || bus.req_offset !== 6'h38) begin
      bad++;
      $display("FAIL rmid_first: got v%b op%0d %h/%h/%h want v1 op0 123/1159/38",
               bus.req_valid, bus.req_op, bus.req_tag, bus.req_index, bus.req_offset);
    end
    cyc();
    bus.req_ready = 1;
    cyc();
    @(negedge clk);
    total++; if (pops !== 1 || bus.req_valid !== 1'b0) begin bad++; $display("FAIL rmid_pops: got %0d valid %b want 1/0", pops, bus.req_valid); end
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_illegal();
    test_saturate();
    test_ctrl_drain();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
